// File: rtl/systolic_a_feeder.sv
// rtl/systolic_a_feeder.sv - skewed A-operand feeder for the systolic MAC array (option: FEEDER_RECIRC_EN)
// Row i is a DIM+i deep shift chain, so each row lags the row above by one enable.
module systolic_a_feeder #(
   parameter int BITS_AB = 32,
   parameter int DIM     = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     en,
   input  logic                     WrEn,
   input  logic [$clog2(DIM)-1:0]   Arow,
   input  logic [BITS_AB*DIM-1:0]   Ain,
   output logic [BITS_AB*DIM-1:0]   Aout,
   output logic                     done
);

   localparam int AW = $clog2(DIM);
   localparam int CW = $clog2(2*DIM) + 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(2*DIM - 1);

   logic          wr_ok;
   logic [CW-1:0] cnt;

   // Out-of-range row addresses (non power-of-two DIM) are dropped entirely.
   assign wr_ok = WrEn && ({1'b0, Arow} < (AW+1)'(DIM));

   for (genvar i = 0; i < DIM; i++) begin : g_row
      localparam int LEN = DIM + i;
      logic [BITS_AB-1:0] s [LEN];
      logic               load;

      assign load = wr_ok && (Arow == AW'(i));

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            for (int j = 0; j < LEN; j++) s[j] <= '0;
         end else if (load) begin
            // Leading zeros create the skew; a loading row never shifts this cycle.
            for (int j = 0; j < i; j++) s[j] <= '0;
            for (int k = 0; k < DIM; k++) s[i+k] <= Ain[k*BITS_AB +: BITS_AB];
         end else if (en) begin
            for (int j = 0; j < LEN-1; j++) s[j] <= s[j+1];
`ifdef FEEDER_RECIRC_EN
            s[LEN-1] <= s[0];
`else
            s[LEN-1] <= '0;
`endif
         end
      end

      assign Aout[i*BITS_AB +: BITS_AB] = s[0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt  <= '0;
         done <= 1'b0;
      end else if (wr_ok) begin
         cnt  <= '0;
         done <= 1'b0;
      end else if (en) begin
         if (cnt != CNT_MAX) cnt <= cnt + CW'(1);
         done <= (cnt >= CNT_MAX - CW'(1));
      end
   end

endmodule

// File: tb/tb_systolic_a_feeder.sv
// tb/tb_systolic_a_feeder.sv - directed vector bench for systolic_a_feeder (DIM=4, BITS_AB=32)
module tb_systolic_a_feeder;

   localparam int BITS_AB = 32;
   localparam int DIM     = 4;

   typedef struct {
      logic         wr;
      logic         en;
      logic [1:0]   arow;
      logic [127:0] ain;
      logic [127:0] aout;
      logic         done;
   } vec_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         en = 1'b0;
   logic         WrEn = 1'b0;
   logic [1:0]   Arow = '0;
   logic [127:0] Ain = '0;
   logic [127:0] Aout;
   logic         done;

   int   checks = 0;
   int   fails  = 0;
   vec_t vt[$];

   always #5 clk = ~clk;

   systolic_a_feeder #(.BITS_AB(BITS_AB), .DIM(DIM)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (en),
      .WrEn (WrEn),
      .Arow (Arow),
      .Ain  (Ain),
      .Aout (Aout),
      .done (done)
   );

   function automatic logic [127:0] p4(input int a, input int b, input int c, input int d);
      return {32'(d), 32'(c), 32'(b), 32'(a)};
   endfunction

   function automatic logic [127:0] rowd(input int r);
      return p4(10*r, 10*r+1, 10*r+2, 10*r+3);
   endfunction

   task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] want);
      checks++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s: got %h required %h", nm, got, want);
      end
   endtask

   task automatic add(input logic wr, input logic e, input int r, input logic [127:0] ain,
                      input logic [127:0] aout, input logic d);
      vec_t v;
      v.wr = wr; v.en = e; v.arow = 2'(r); v.ain = ain; v.aout = aout; v.done = d;
      vt.push_back(v);
   endtask

   task automatic step(input logic wr, input logic e, input int r, input logic [127:0] ain);
      WrEn = wr; en = e; Arow = 2'(r); Ain = ain;
      @(posedge clk); #1;
   endtask

   initial begin
      // Full load, then drain past the done point.
      for (int r = 0; r < 4; r++) add(1, 0, r, rowd(r), '0, 0);
      add(0, 1, 0, '0, p4(1, 10, 0, 0),   0);
      add(0, 1, 0, '0, p4(2, 11, 20, 0),  0);
      add(0, 1, 0, '0, p4(3, 12, 21, 30), 0);
      add(0, 1, 0, '0, p4(0, 13, 22, 31), 0);
      add(0, 1, 0, '0, p4(0, 0, 23, 32),  0);
      add(0, 1, 0, '0, p4(0, 0, 0, 33),   0);
      add(0, 1, 0, '0, '0, 1);
      add(0, 1, 0, '0, '0, 1);
      // Reload, then load row 2 while everything else shifts.
      for (int r = 0; r < 4; r++) add(1, 0, r, rowd(r), '0, 0);
      add(0, 1, 0, '0, p4(1, 10, 0, 0),  0);
      add(0, 1, 0, '0, p4(2, 11, 20, 0), 0);
      add(1, 1, 2, p4(40, 41, 42, 43), p4(3, 12, 0, 30), 0);
      add(0, 1, 0, '0, p4(0, 13, 0, 31),  0);
      add(0, 1, 0, '0, p4(0, 0, 40, 32),  0);
      add(0, 1, 0, '0, p4(0, 0, 41, 33),  0);
      add(0, 1, 0, '0, p4(0, 0, 42, 0),   0);
      add(0, 1, 0, '0, p4(0, 0, 43, 0),   0);
      // Row 3 reload at cnt=5: three leading zeros, counter restarts.
      add(1, 0, 3, p4(50, 51, 52, 53), p4(0, 0, 43, 0), 0);
      add(0, 1, 0, '0, '0, 0);
      add(0, 1, 0, '0, '0, 0);
      add(0, 1, 0, '0, p4(0, 0, 0, 50), 0);
      add(0, 1, 0, '0, p4(0, 0, 0, 51), 0);
      add(0, 1, 0, '0, p4(0, 0, 0, 52), 0);
      add(0, 1, 0, '0, p4(0, 0, 0, 53), 0);
      add(0, 1, 0, '0, '0, 1);
      // Load while done is high drops done on the next edge.
      add(1, 0, 3, p4(60, 61, 62, 63), '0, 0);
      add(0, 1, 0, '0, '0, 0);
      add(0, 1, 0, '0, '0, 0);
      add(0, 1, 0, '0, p4(0, 0, 0, 60), 0);

      repeat (2) @(posedge clk);
      #1;
      chk("reset aout", Aout, '0);
      chk("reset done", {127'd0, done}, '0);
      rst_n = 1'b1;

      foreach (vt[i]) begin
         step(vt[i].wr, vt[i].en, int'(vt[i].arow), vt[i].ain);
         chk($sformatf("vec%0d aout", i), Aout, vt[i].aout);
         chk($sformatf("vec%0d done", i), {127'd0, done}, {127'd0, vt[i].done});
      end

      // Idle cycles must hold everything.
      for (int c = 0; c < 10; c++) begin
         step(0, 0, 0, '0);
         chk($sformatf("hold%0d aout", c), Aout, p4(0, 0, 0, 60));
         chk($sformatf("hold%0d done", c), {127'd0, done}, '0);
      end

      // Asynchronous reset in the middle of a drain.
      for (int r = 0; r < 4; r++) step(1, 0, r, rowd(r));
      for (int n = 0; n < 3; n++) step(0, 1, 0, '0);
      chk("pre-reset aout", Aout, p4(3, 12, 21, 30));
      WrEn = 1'b0; en = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("async reset aout", Aout, '0);
      chk("async reset done", {127'd0, done}, '0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int n = 1; n <= 7; n++) begin
         step(0, 1, 0, '0);
         chk($sformatf("post-reset shift%0d aout", n), Aout, '0);
         chk($sformatf("post-reset shift%0d done", n), {127'd0, done}, {127'd0, (n == 7)});
      end
      en = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
